// File: rtl/layernorm_var_accum.sv
// Streaming mean/variance stage feeding the 1/sqrt LUT; Q16.16 in, Q16.16 mean and variance+EPS out.
// Latency: out_valid rises two edges after the last element of a vector is accepted; period >= N+3 cycles.
// Backpressure: in_ready is low from the last element until the result is popped; the result holds while out_ready is low.
// Optional build macro LUT_RANGE_CLAMP_EN clamps out_var to the LUT index range [0x0001_0000, 0x0009_FFFF].
module layernorm_var_accum #(
   parameter int                   BIT_WIDTH    = 32,
   parameter int                   VEC_LEN_LOG2 = 6,
   parameter logic [BIT_WIDTH-1:0] EPS          = 32'h0000_0001
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out_mean,
   output logic [BIT_WIDTH-1:0] out_var
);

   localparam int FRAC  = 16;
   localparam int SUM_W = BIT_WIDTH + VEC_LEN_LOG2;

   localparam logic [1:0] S_ACCUM = 2'd0;
   localparam logic [1:0] S_MEAN  = 2'd1;
   localparam logic [1:0] S_VAR   = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic [VEC_LEN_LOG2-1:0] CNT_LAST = '1;

`ifdef LUT_RANGE_CLAMP_EN
   localparam logic [BIT_WIDTH-1:0] VAR_MIN = BIT_WIDTH'(32'h0001_0000);
   localparam logic [BIT_WIDTH-1:0] VAR_MAX = BIT_WIDTH'(32'h0009_FFFF);
`endif

   logic [1:0]                    state;
   logic [VEC_LEN_LOG2-1:0]       cnt_q;
   logic signed [SUM_W-1:0]       sum_q;
   logic [63:0]                   sumsq_q;
   logic signed [BIT_WIDTH-1:0]   mean_q;
   logic [63:0]                   ex2_q;

   logic signed [2*BIT_WIDTH-1:0] sq_full;
   logic [63:0]                   sq_term;
   logic signed [2*BIT_WIDTH-1:0] msq_full;
   logic [63:0]                   msq;
   logic [63:0]                   diff;
   logic [64:0]                   var_eps;
   logic [BIT_WIDTH-1:0]          var_sat;
   logic [BIT_WIDTH-1:0]          var_final;
   logic                          in_hs;

   assign in_hs = in_valid && in_ready;

   // Per-element square, rescaled to Q16.16 before accumulation (always non-negative).
   assign sq_full = $signed(in_data) * $signed(in_data);
   assign sq_term = 64'(sq_full >>> FRAC);

   // Variance = E[x^2] - mean^2, clipped at zero, plus epsilon, saturated to the output width.
   assign msq_full = mean_q * mean_q;
   assign msq      = 64'(msq_full >>> FRAC);
   assign diff     = (ex2_q > msq) ? (ex2_q - msq) : 64'd0;
   assign var_eps  = {1'b0, diff} + 65'(EPS);
   assign var_sat  = (|var_eps[64:BIT_WIDTH]) ? '1 : var_eps[BIT_WIDTH-1:0];

`ifdef LUT_RANGE_CLAMP_EN
   // Keep the LUT index inside the populated table so it never returns its default entry.
   always_comb begin
      var_final = var_sat;
      if (var_sat < VAR_MIN)
         var_final = VAR_MIN;
      else if (var_sat > VAR_MAX)
         var_final = VAR_MAX;
   end
`else
   assign var_final = var_sat;
`endif

   // Control FSM plus accumulators; every output is a register so no in_* -> out_* or out_ready -> in_ready path exists.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_ACCUM;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_mean  <= '0;
         out_var   <= '0;
         cnt_q     <= '0;
         sum_q     <= '0;
         sumsq_q   <= '0;
         mean_q    <= '0;
         ex2_q     <= '0;
      end else begin
         case (state)
            S_ACCUM: begin
               in_ready <= 1'b1;
               if (in_hs) begin
                  sum_q   <= sum_q + $signed({{VEC_LEN_LOG2{in_data[BIT_WIDTH-1]}}, in_data});
                  sumsq_q <= sumsq_q + sq_term;
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     in_ready <= 1'b0;
                     state    <= S_MEAN;
                  end
               end
            end
            S_MEAN: begin
               // Arithmetic shift floors toward -inf, matching the LUT's expected mean rounding.
               mean_q <= BIT_WIDTH'(sum_q >>> VEC_LEN_LOG2);
               ex2_q  <= sumsq_q >> VEC_LEN_LOG2;
               state  <= S_VAR;
            end
            S_VAR: begin
               out_mean  <= mean_q;
               out_var   <= var_final;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  cnt_q     <= '0;
                  sum_q     <= '0;
                  sumsq_q   <= '0;
                  state     <= S_ACCUM;
               end
            end
            default: state <= S_ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_layernorm_var_accum.sv
// Bench for layernorm_var_accum with N=4, EPS=0: directed vectors, backpressure, mid-vector reset, random vectors.
// Expected mean/variance come from a plain-arithmetic model of the statistics on the accepted elements.
// Honours LUT_RANGE_CLAMP_EN in both the model and the directed expectations.
module tb_layernorm_var_accum;

   localparam int N = 4;

`ifdef LUT_RANGE_CLAMP_EN
   localparam logic [31:0] EXP_VAR_ONES = 32'h0001_0000;
   localparam logic [31:0] EXP_VAR_PM4  = 32'h0009_FFFF;
`else
   localparam logic [31:0] EXP_VAR_ONES = 32'h0000_0000;
   localparam logic [31:0] EXP_VAR_PM4  = 32'h0010_0000;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_mean;
   logic [31:0] out_var;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] vec [N];

   layernorm_var_accum #(
      .BIT_WIDTH   (32),
      .VEC_LEN_LOG2(2),
      .EPS         (32'h0000_0000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_mean (out_mean),
      .out_var  (out_var)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference statistics: floor mean, E[x^2] from per-element Q16.16 squares, clipped/saturated variance.
   task automatic model(output logic [31:0] m, output logic [31:0] v);
      longint s, sq, mn, ex2, msq, d;
      s  = 0;
      sq = 0;
      for (int i = 0; i < N; i++) begin
         longint x;
         x  = longint'(signed'(vec[i]));
         s  = s + x;
         sq = sq + (x * x) / 65536;
      end
      mn = s / N;
      if (s < 0 && (s % N) != 0) mn = mn - 1;
      ex2 = sq / N;
      msq = (mn * mn) / 65536;
      d   = ex2 - msq;
      if (d < 0) d = 0;
      if (d > longint'(32'hFFFF_FFFF)) d = longint'(32'hFFFF_FFFF);
`ifdef LUT_RANGE_CLAMP_EN
      if (d < longint'(32'h0001_0000)) d = longint'(32'h0001_0000);
      if (d > longint'(32'h0009_FFFF)) d = longint'(32'h0009_FFFF);
`endif
      m = mn[31:0];
      v = d[31:0];
   endtask

   task automatic send_elem(input logic [31:0] x, input int gap);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = x;
      t = 0;
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      repeat (gap) @(negedge clk);
   endtask

   task automatic run_vec(input string tag, input int gap_max, input int hold,
                          input bit use_const, input logic [31:0] c_mean, input logic [31:0] c_var);
      logic [31:0] em, ev;
      int edges;
      model(em, ev);
      for (int i = 0; i < N; i++)
         send_elem(vec[i], (i == N - 1) ? 0 : $urandom_range(gap_max, 0));
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk({tag, "_latency"}, 32'(edges), 32'd2);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_mean"}, out_mean, em);
      chk({tag, "_var"}, out_var, ev);
      if (use_const) begin
         chk({tag, "_mean_const"}, out_mean, c_mean);
         chk({tag, "_var_const"}, out_var, c_var);
      end
      chk({tag, "_in_ready_out"}, {31'b0, in_ready}, 32'd0);
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
         chk({tag, "_hold_mean"}, out_mean, em);
         chk({tag, "_hold_var"}, out_var, ev);
         chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_popped"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_in_ready_after_pop"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_mean", out_mean, 32'd0);
      chk("rst_out_var", out_var, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_rel_in_ready_low", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_rel_in_ready_high", {31'b0, in_ready}, 32'd1);

      // Directed vectors
      vec = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
      run_vec("ones", 0, 0, 1'b1, 32'h0001_0000, EXP_VAR_ONES);

      vec = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000};
      run_vec("pm1", 1, 0, 1'b1, 32'h0000_0000, 32'h0001_0000);

      vec = '{32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 32'h0002_0000};
      run_vec("zz22_bp", 0, 5, 1'b1, 32'h0001_0000, 32'h0001_0000);

      vec = '{32'h0004_0000, 32'hFFFC_0000, 32'h0004_0000, 32'hFFFC_0000};
      run_vec("pm4", 2, 0, 1'b1, 32'h0000_0000, EXP_VAR_PM4);

      // Reset after two accepted elements
      send_elem(32'h0007_0000, 0);
      send_elem(32'h1234_5678, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_out_mean", out_mean, 32'd0);
      chk("midrst_out_var", out_var, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      vec = '{32'h0003_0000, 32'hFFFD_0000, 32'h0003_0000, 32'hFFFD_0000};
      run_vec("post_rst", 0, 0, 1'b1, 32'h0000_0000, 32'h0009_0000);

      // Random vectors: alternate modest magnitudes with full-range words that exercise saturation
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < N; i++) begin
            if (k % 2 == 0)
               vec[i] = ($urandom & 32'h001F_FFFF) - 32'h0010_0000;
            else
               vec[i] = $urandom;
         end
         run_vec("rand", 2, $urandom_range(3, 0), 1'b0, 32'h0, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
